// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S capture path.
//   i2s_rx_state_t : receive FSM states
//   LEFT / RIGHT   : channel encoding, matches the LRCLK level of the slot
package i2s_pkg;

  typedef enum logic [1:0] {
    SYNC    = 2'd0,
    CAPTURE = 2'd1,
    PAD     = 2'd2
  } i2s_rx_state_t;

  localparam logic LEFT  = 1'b0;
  localparam logic RIGHT = 1'b1;

endpackage

// File: rtl/i2s_edge_sync.sv
// Registers the I2S pins into the CLK domain and flags SCLK rising edges.
//   clk, rst_n : MCLK and async active-low reset
//   sclk       : bit clock pin
//   lrclk      : word select pin
//   dout       : serial data pin
//   sclk_rise  : high for one CLK when a registered SCLK rise is seen
//   lrclk_q    : LRCLK aligned with sclk_rise
//   dout_q     : DOUT aligned with sclk_rise
module i2s_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic sclk,
  input  logic lrclk,
  input  logic dout,
  output logic sclk_rise,
  output logic lrclk_q,
  output logic dout_q
);

  logic sclk_q;
  logic sclk_qq;
  logic sclk_d;
  logic lrclk_d;
  logic dout_d;

  always_comb begin
    sclk_d  = sclk;
    lrclk_d = lrclk;
    dout_d  = dout;
  end

  // LRCLK/DOUT are consumed from the first stage so they line up with
  // sclk_q; the second stage exists only on SCLK to detect its edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_q  <= 1'b0;
      sclk_qq <= 1'b0;
      lrclk_q <= 1'b0;
      dout_q  <= 1'b0;
    end else begin
      sclk_q  <= sclk_d;
      sclk_qq <= sclk_q;
      lrclk_q <= lrclk_d;
      dout_q  <= dout_d;
    end
  end

  assign sclk_rise = sclk_q & ~sclk_qq;

endmodule

// File: rtl/i2s_rx.sv
// I2S receiver: deserialises one left and one right word per frame from the
// codec and writes the {left,right} pair into a CLK-domain sample FIFO.
//   CLK, RESET_N  : MCLK and async active-low reset
//   ENABLE        : capture enable; low resynchronises and blocks writes
//   SCLK, LRCLK   : FPGA-generated bit clock and word select (0 = left)
//   DOUT          : codec serial data, MSB first, one-bit I2S delay
//   FIFO_FULL     : FIFO write-side full, sampled in the write-decision cycle
//   AUDIO_IN      : {left,right} pair, valid while FIFO_WRITE is high
//   FIFO_WRITE    : single-cycle write strobe
//   OVERRUN       : sticky, a frame was dropped on FIFO_FULL
//   FRAME_ERR     : sticky, a slot ended before SAMPLE_WIDTH bits arrived
//   CLR_FLAGS     : clears OVERRUN/FRAME_ERR; a same-cycle set wins
module i2s_rx
  import i2s_pkg::*;
#(
  parameter int unsigned SAMPLE_WIDTH = 16,
  parameter int unsigned CNT_WIDTH    = 6
) (
  input  logic                      CLK,
  input  logic                      RESET_N,
  input  logic                      ENABLE,
  input  logic                      SCLK,
  input  logic                      LRCLK,
  input  logic                      DOUT,
  input  logic                      FIFO_FULL,
  output logic [2*SAMPLE_WIDTH-1:0] AUDIO_IN,
  output logic                      FIFO_WRITE,
  output logic                      OVERRUN,
  output logic                      FRAME_ERR,
  input  logic                      CLR_FLAGS
);

  localparam int unsigned PAIR_W = 2 * SAMPLE_WIDTH;

  logic sclk_rise;
  logic lrclk_q;
  logic dout_q;
  logic boundary;

  i2s_rx_state_t           state_q,   state_d;
  logic [CNT_WIDTH-1:0]    cnt_q,     cnt_d;
  logic                    ch_q,      ch_d;
  logic                    lr_prev_q, lr_prev_d;
  logic [SAMPLE_WIDTH-1:0] sreg_l_q,  sreg_l_d;
  logic [SAMPLE_WIDTH-1:0] sreg_r_q,  sreg_r_d;
  logic                    done_q,    done_d;
  logic [PAIR_W-1:0]       audio_q,   audio_d;
  logic                    wr_q,      wr_d;
  logic                    ovr_q,     ovr_d;
  logic                    ferr_q,    ferr_d;

  i2s_edge_sync u_sync (
    .clk       (CLK),
    .rst_n     (RESET_N),
    .sclk      (SCLK),
    .lrclk     (LRCLK),
    .dout      (DOUT),
    .sclk_rise (sclk_rise),
    .lrclk_q   (lrclk_q),
    .dout_q    (dout_q)
  );

  // Slot boundary: the word select changed since the previous bit.
  assign boundary = (lrclk_q != lr_prev_q);

  // Next-state, capture and write-decision logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ch_d      = ch_q;
    lr_prev_d = lr_prev_q;
    sreg_l_d  = sreg_l_q;
    sreg_r_d  = sreg_r_q;
    audio_d   = audio_q;
    done_d    = 1'b0;
    wr_d      = 1'b0;
    ovr_d     = CLR_FLAGS ? 1'b0 : ovr_q;
    ferr_d    = CLR_FLAGS ? 1'b0 : ferr_q;

    if (sclk_rise) begin
      lr_prev_d = lrclk_q;
    end

    if (!ENABLE) begin
      state_d = SYNC;
      cnt_d   = '0;
    end else begin
      // Pair completed on the previous bit: write it or count a drop.
      if (done_q) begin
        if (FIFO_FULL) begin
          ovr_d = 1'b1;
        end else begin
          wr_d    = 1'b1;
          audio_d = {sreg_l_q, sreg_r_q};
        end
      end

      if (sclk_rise) begin
        case (state_q)
          SYNC: begin
            // Boundary bit carries the previous word's LSB and is dropped.
            if (boundary && (lrclk_q == LEFT)) begin
              state_d = CAPTURE;
              cnt_d   = '0;
              ch_d    = LEFT;
            end
          end
          CAPTURE: begin
            if (boundary) begin
              ferr_d  = 1'b1;
              state_d = SYNC;
              cnt_d   = '0;
            end else begin
              if (ch_q == LEFT) begin
                sreg_l_d = {sreg_l_q[SAMPLE_WIDTH-2:0], dout_q};
              end else begin
                sreg_r_d = {sreg_r_q[SAMPLE_WIDTH-2:0], dout_q};
              end
              cnt_d = cnt_q + CNT_WIDTH'(1);
              if (cnt_q == CNT_WIDTH'(SAMPLE_WIDTH - 1)) begin
                state_d = PAD;
                done_d  = (ch_q == RIGHT);
              end
            end
          end
          PAD: begin
            if (boundary) begin
              state_d = CAPTURE;
              cnt_d   = '0;
              ch_d    = lrclk_q;
            end
          end
          default: begin
            state_d = SYNC;
            cnt_d   = '0;
          end
        endcase
      end
    end
  end

  // State and output registers.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= SYNC;
      cnt_q     <= '0;
      ch_q      <= LEFT;
      lr_prev_q <= 1'b0;
      sreg_l_q  <= '0;
      sreg_r_q  <= '0;
      done_q    <= 1'b0;
      audio_q   <= '0;
      wr_q      <= 1'b0;
      ovr_q     <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ch_q      <= ch_d;
      lr_prev_q <= lr_prev_d;
      sreg_l_q  <= sreg_l_d;
      sreg_r_q  <= sreg_r_d;
      done_q    <= done_d;
      audio_q   <= audio_d;
      wr_q      <= wr_d;
      ovr_q     <= ovr_d;
      ferr_q    <= ferr_d;
    end
  end

  assign AUDIO_IN   = audio_q;
  assign FIFO_WRITE = wr_q;
  assign OVERRUN    = ovr_q;
  assign FRAME_ERR  = ferr_q;

endmodule

// File: tb/tb_i2s_rx.sv
// Self-checking bench for i2s_rx: a codec model drives I2S frames, expected
// {left,right} pairs and their write cycle go into a scoreboard queue, and a
// monitor compares every FIFO_WRITE against it.
module tb_i2s_rx;

  typedef struct packed {
    logic [31:0] data;
    int unsigned cyc;
  } exp_t;

  logic        clk    = 1'b0;
  logic        rst_n  = 1'b0;
  logic        enable = 1'b1;
  logic        sclk   = 1'b0;
  logic        lrclk  = 1'b0;
  logic        dout   = 1'b0;
  logic        full   = 1'b0;
  logic        clr    = 1'b0;
  logic [31:0] audio_in;
  logic        fifo_write;
  logic        overrun;
  logic        frame_err;

  int unsigned cyc      = 0;
  int          total    = 0;
  int          bad      = 0;
  int          nwr      = 0;
  logic        prev_wr  = 1'b0;
  logic        prev_bit = 1'b0;
  exp_t        sb[$];

  i2s_rx #(.SAMPLE_WIDTH(16), .CNT_WIDTH(6)) dut (
    .CLK        (clk),
    .RESET_N    (rst_n),
    .ENABLE     (enable),
    .SCLK       (sclk),
    .LRCLK      (lrclk),
    .DOUT       (dout),
    .FIFO_FULL  (full),
    .AUDIO_IN   (audio_in),
    .FIFO_WRITE (fifo_write),
    .OVERRUN    (overrun),
    .FRAME_ERR  (frame_err),
    .CLR_FLAGS  (clr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitor: every write must match the oldest expected pair and its cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (fifo_write) begin
        exp_t e;
        nwr++;
        chk("back_to_back_write", 64'(prev_wr), 64'd0);
        chk("write_expected", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("write_data", 64'(audio_in), 64'(e.data));
          chk("write_cycle", 64'(cyc), 64'(e.cyc));
        end
      end
      prev_wr = fifo_write;
    end else begin
      prev_wr = 1'b0;
    end
  end

  // One SCLK period: low phase drives LRCLK/DOUT, then the rising edge.
  task automatic sclk_cycle(input logic lr, input logic b);
    @(posedge clk); #1;
    sclk  = 1'b0;
    lrclk = lr;
    dout  = b;
    @(posedge clk); #1;
    sclk  = 1'b1;
  endtask

  // Slot positions from..to-1. Bit position j carries word bit 15-j (pad after
  // 16) and appears on the wire one SCLK later (I2S delay), so the LSB is on
  // rise 16; a pushed pair is written 3 CLK after that rise.
  task automatic send_slot(input logic lr, input logic [15:0] w, input int from,
                           input int to, input bit do_push, input logic [31:0] pair);
    for (int j = from; j < to; j++) begin
      logic nb;
      nb = (j < 16) ? w[15-j] : 1'($urandom);
      sclk_cycle(lr, prev_bit);
      prev_bit = nb;
      if (do_push && j == 16) sb.push_back('{data: pair, cyc: cyc + 3});
    end
  endtask

  task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input int s, input bit do_push);
    send_slot(1'b0, l, 0, s, 1'b0, 32'd0);
    send_slot(1'b1, r, 0, s, do_push, {l, r});
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    #1;
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
  endtask

  task automatic pulse_clr();
    @(posedge clk); #1 clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n0;
    logic [15:0] l, r;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_audio_in", 64'(audio_in), 64'd0);
    chk("rst_fifo_write", 64'(fifo_write), 64'd0);
    chk("rst_overrun", 64'(overrun), 64'd0);
    chk("rst_frame_err", 64'(frame_err), 64'd0);
    rst_n = 1'b1;
    send_slot(1'b1, 16'h0, 0, 32, 1'b0, 32'd0);

    // 1: single known frame with 32-bit slots.
    n0 = nwr;
    send_frame(16'hA5C3, 16'h0F1E, 32, 1'b1);
    drain();
    chk("t1_write_count", 64'(nwr - n0), 64'd1);

    // 2: reset released mid right slot; partial frame must not write.
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1;
    chk("t2_rst_audio_in", 64'(audio_in), 64'd0);
    chk("t2_rst_fifo_write", 64'(fifo_write), 64'd0);
    send_slot(1'b0, 16'(($urandom)), 0, 32, 1'b0, 32'd0);
    send_slot(1'b1, 16'(($urandom)), 0, 10, 1'b0, 32'd0);
    rst_n = 1'b1;
    send_slot(1'b1, 16'(($urandom)), 10, 32, 1'b0, 32'd0);
    n0 = nwr;
    l = 16'($urandom); r = 16'($urandom);
    send_frame(l, r, 32, 1'b1);
    drain();
    chk("t2_write_count", 64'(nwr - n0), 64'd1);
    chk("t2_frame_err", 64'(frame_err), 64'd0);

    // 3: FIFO full for one frame -> dropped, OVERRUN sticky until cleared.
    full = 1'b1;
    send_frame(16'h1234, 16'h5678, 32, 1'b0);
    full = 1'b0;
    chk("t3_overrun_set", 64'(overrun), 64'd1);
    send_frame(16'h9ABC, 16'hDEF0, 32, 1'b1);
    drain();
    chk("t3_overrun_sticky", 64'(overrun), 64'd1);
    pulse_clr();
    #1;
    chk("t3_overrun_cleared", 64'(overrun), 64'd0);

    // 4: left slot cut short after 10 bits -> FRAME_ERR, resync.
    send_slot(1'b0, 16'hFFFF, 0, 11, 1'b0, 32'd0);
    send_slot(1'b1, 16'hFFFF, 0, 32, 1'b0, 32'd0);
    chk("t4_frame_err_set", 64'(frame_err), 64'd1);
    send_frame(16'h4B2D, 16'hC001, 32, 1'b1);
    drain();
    pulse_clr();
    #1;
    chk("t4_frame_err_cleared", 64'(frame_err), 64'd0);

    // 5: ENABLE low mid-left, high again mid-right.
    send_slot(1'b0, 16'hAAAA, 0, 6, 1'b0, 32'd0);
    enable = 1'b0;
    send_slot(1'b0, 16'hAAAA, 6, 32, 1'b0, 32'd0);
    send_slot(1'b1, 16'h5555, 0, 8, 1'b0, 32'd0);
    enable = 1'b1;
    send_slot(1'b1, 16'h5555, 8, 32, 1'b0, 32'd0);
    n0 = nwr;
    send_frame(16'h8000, 16'h7FFF, 32, 1'b1);
    drain();
    chk("t5_write_count", 64'(nwr - n0), 64'd1);

    // 6: back-to-back random frames at minimum slot length.
    n0 = nwr;
    for (int i = 0; i < 1000; i++) begin
      send_frame(16'($urandom), 16'($urandom), 17, 1'b1);
    end
    drain();
    chk("t6_write_count", 64'(nwr - n0), 64'd1000);
    chk("t6_frame_err", 64'(frame_err), 64'd0);
    chk("t6_overrun", 64'(overrun), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
